// File: rtl/ch_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ch_frame_sequencer
// Purpose  : Frame-level controller for the cumulative-histogram bank.
//            Clears the bank, forwards and counts the frame pixels, then reads
//            each bin's CDF and scales it into an equalization LUT entry:
//              lut[v] = min(cdf[v] * MAXV / pix_count, MAXV)
//            computed by a restoring serial divider (one quotient bit/cycle).
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst       clock; synchronous active-high reset
//   frame_start    start-of-frame pulse
//   frame_end      end-of-frame pulse
//   pix_valid_in   pixel strobe from the source
//   pix_valid_out  pixel strobe to the bank (only while accumulating)
//   unit_clr       bank clear pulse
//   bin_sel        bin being read (drives external CDF mux)
//   cdf_in         CDF of selected bin, valid one cycle after bin_sel changes
//   lut_wr_en      LUT write strobe; lut_addr / lut_data its address / data
//   busy           high whenever not idle
//   done           one-cycle pulse after the last LUT write
//   overrun        one-cycle pulse on frame_start during a scan
// ============================================================================
module ch_frame_sequencer #(
  parameter int PixelSize  = 8,
  parameter int histoWidth = $clog2(640*480)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  frame_end,
  input  logic                  pix_valid_in,
  output logic                  pix_valid_out,
  output logic                  unit_clr,
  output logic [PixelSize-1:0]  bin_sel,
  input  logic [histoWidth-1:0] cdf_in,
  output logic                  lut_wr_en,
  output logic [PixelSize-1:0]  lut_addr,
  output logic [PixelSize-1:0]  lut_data,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun
);

  localparam int D    = histoWidth + PixelSize;  // numerator width = divider steps
  localparam int MAXV = (1 << PixelSize) - 1;
  localparam int CW   = $clog2(D);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_SEL, S_LATCH, S_DIV, S_WRITE, S_DONE
  } state_t;

  state_t                state;
  logic [histoWidth-1:0] pix_count;
  logic [histoWidth-1:0] rem;       // partial remainder, always < divisor
  logic [D-1:0]          quo;       // numerator shifts out as quotient shifts in
  logic [CW-1:0]         div_cnt;
  logic                  div_zero;  // divisor was zero: result forced to 0

  // One restoring-division step, evaluated combinationally so the final
  // quotient bit is available on the same edge that enters WRITE.
  logic [histoWidth:0]   trial;
  logic [histoWidth:0]   diff;
  logic                  take;
  logic [histoWidth-1:0] rem_next;
  logic [D-1:0]          quo_next;
  logic [PixelSize-1:0]  lut_val;

  always_comb begin
    trial    = {rem, quo[D-1]};
    diff     = trial - {1'b0, pix_count};
    take     = (trial >= {1'b0, pix_count});
    rem_next = take ? diff[histoWidth-1:0] : trial[histoWidth-1:0];
    quo_next = {quo[D-2:0], take};
    if (div_zero)
      lut_val = '0;
    else if (quo_next > D'(MAXV))
      lut_val = PixelSize'(MAXV);
    else
      lut_val = quo_next[PixelSize-1:0];
  end

  // Bank only sees pixels while accumulating; CLEAR-cycle pixels are dropped.
  assign pix_valid_out = (state == S_ACCUM) && pix_valid_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      pix_count <= '0;
      rem       <= '0;
      quo       <= '0;
      div_cnt   <= '0;
      div_zero  <= 1'b0;
      unit_clr  <= 1'b0;
      bin_sel   <= '0;
      lut_wr_en <= 1'b0;
      lut_addr  <= '0;
      lut_data  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      unit_clr  <= 1'b0;
      lut_wr_en <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;

      if (frame_start && (state inside {S_SEL, S_LATCH, S_DIV, S_WRITE, S_DONE}))
        overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (frame_start) begin
            state    <= S_CLEAR;
            unit_clr <= 1'b1;
            busy     <= 1'b1;
          end
        end

        S_CLEAR: begin
          pix_count <= '0;
          state     <= S_ACCUM;
        end

        S_ACCUM: begin
          if (frame_start) begin
            // Restart: the CLEAR state discards the partial count.
            state    <= S_CLEAR;
            unit_clr <= 1'b1;
          end else begin
            if (pix_valid_in && (pix_count != '1))
              pix_count <= pix_count + histoWidth'(1);
            if (frame_end) begin
              state   <= S_SEL;
              bin_sel <= '0;
            end
          end
        end

        S_SEL: begin
          state <= S_LATCH;
        end

        S_LATCH: begin
          rem      <= '0;
          quo      <= D'(cdf_in) * D'(MAXV);
          div_zero <= (pix_count == '0);
          div_cnt  <= '0;
          state    <= S_DIV;
        end

        S_DIV: begin
          rem     <= rem_next;
          quo     <= quo_next;
          div_cnt <= div_cnt + CW'(1);
          if (div_cnt == CW'(D - 1)) begin
            state     <= S_WRITE;
            lut_wr_en <= 1'b1;
            lut_addr  <= bin_sel;
            lut_data  <= lut_val;
          end
        end

        S_WRITE: begin
          if (bin_sel == PixelSize'(MAXV)) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            bin_sel <= bin_sel + PixelSize'(1);
            state   <= S_SEL;
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          bin_sel <= '0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ch_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ch_frame_sequencer
// Purpose  : Self-checking bench for ch_frame_sequencer. A CDF table stands in
//            for the histogram bank; expected LUT writes are queued when a
//            frame ends and popped as the DUT writes them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ch_frame_sequencer;

  localparam int PS   = 8;
  localparam int HW   = 19;
  localparam int D    = PS + HW;
  localparam int NBIN = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start, frame_end, pix_valid_in;
  logic          pix_valid_out, unit_clr, lut_wr_en, busy, done, overrun;
  logic [PS-1:0] bin_sel, lut_addr, lut_data;
  logic [HW-1:0] cdf_in = '0;

  ch_frame_sequencer #(.PixelSize(PS), .histoWidth(HW)) dut (
    .clk(clk), .rst(rst),
    .frame_start(frame_start), .frame_end(frame_end),
    .pix_valid_in(pix_valid_in), .pix_valid_out(pix_valid_out),
    .unit_clr(unit_clr), .bin_sel(bin_sel), .cdf_in(cdf_in),
    .lut_wr_en(lut_wr_en), .lut_addr(lut_addr), .lut_data(lut_data),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;     // posedges so far
  int k_edge  = 0;     // posedge count at which frame_end was sampled
  int clr_count = 0;
  int wr_count  = 0;
  int first_wr_cyc = -1;
  int cdf_tab [NBIN];
  logic [15:0] sb [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Bank model: CDF of the selected bin appears one cycle after bin_sel.
  always @(posedge clk) cdf_in <= HW'(cdf_tab[bin_sel]);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int ref_lut(input int cdf, input int n);
    int q;
    if (n == 0) return 0;
    q = (cdf * 255) / n;
    return (q > 255) ? 255 : q;
  endfunction

  // Monitor: every LUT write must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [15:0] e;
    if (unit_clr) clr_count++;
    if (lut_wr_en) begin
      wr_count++;
      if (first_wr_cyc < 0) first_wr_cyc = cyc;
      if (sb.size() == 0)
        check("lut_wr_spurious", 32'(lut_wr_en), 32'd0);
      else begin
        e = sb.pop_front();
        check("lut_wr", 32'({lut_addr, lut_data}), 32'(e));
      end
    end
  end

  // Returns at the negedge of the CLEAR cycle.
  task automatic start_frame();
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
  endtask

  task automatic pixels(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid_in = 1'b1;
      @(negedge clk);
    end
    pix_valid_in = 1'b0;
  endtask

  // Drives frame_end (pix_valid_in left as the caller set it) and queues
  // the expected LUT contents for a frame of npix pixels.
  task automatic end_frame(input int npix);
    frame_end = 1'b1;
    k_edge = cyc + 1;
    for (int v = 0; v < NBIN; v++)
      sb.push_back({8'(v), 8'(ref_lut(cdf_tab[v], npix))});
    @(negedge clk);
    frame_end    = 1'b0;
    pix_valid_in = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int  low  = 0;
    bit  seen = 1'b0;
    dcyc = -1;
    for (int i = 0; i < 9000 && !seen; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        dcyc = cyc;
      end else if (!busy) low++;
    end
    check("done_seen", 32'(seen), 32'd1);
    check("busy_scan", 32'(low), 32'd0);
  endtask

  task automatic wait_bin(input int b);
    bit seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      @(negedge clk);
      if (bin_sel == PS'(b)) seen = 1'b1;
    end
    check("bin_reached", 32'(seen), 32'd1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},    32'(busy), 32'd0);
    check({tag, "_done"},    32'(done), 32'd0);
    check({tag, "_wr"},      32'(lut_wr_en), 32'd0);
    check({tag, "_clr"},     32'(unit_clr), 32'd0);
    check({tag, "_ovr"},     32'(overrun), 32'd0);
    check({tag, "_bin_sel"}, 32'(bin_sel), 32'd0);
    check({tag, "_pvo"},     32'(pix_valid_out), 32'd0);
  endtask

  initial begin
    int dcyc;
    int snap;
    rst = 1'b1; frame_start = 1'b0; frame_end = 1'b0; pix_valid_in = 1'b0;
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = 0;
    repeat (3) @(negedge clk);
    check_idle("rst");
    check("rst_lut_addr", 32'(lut_addr), 32'd0);
    check("rst_lut_data", 32'(lut_data), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // --- 4-pixel frame; CLEAR-cycle pixel dropped, frame_end pixel counted
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = (v == 0) ? 1 : (v == 255) ? 4 : 2;
    first_wr_cyc = -1;
    start_frame();
    check("clr_unit_clr", 32'(unit_clr), 32'd1);
    check("clr_busy", 32'(busy), 32'd1);
    pix_valid_in = 1'b1;
    #1 check("clr_pvo_drop", 32'(pix_valid_out), 32'd0);
    @(negedge clk);                         // ACCUM
    #1 check("acc_pvo_fwd", 32'(pix_valid_out), 32'd1);
    @(negedge clk);                         // 1 counted
    @(negedge clk); pix_valid_in = 1'b0;    // 2 counted
    @(negedge clk); pix_valid_in = 1'b1;
    @(negedge clk);                         // 3 counted
    end_frame(4);                           // 4th counted with frame_end
    wait_done(dcyc);
    // Spec cycle k+n is the cycle after n-1 edges past the frame_end edge.
    check("first_wr_lat", 32'(first_wr_cyc - k_edge), 32'(D + 2));
    check("done_lat", 32'(dcyc - k_edge), 32'(NBIN * (D + 3)));
    check("sb_empty_a", 32'(sb.size()), 32'd0);
    @(negedge clk);
    check_idle("post_a");

    // --- empty frame: count zero forces every entry to 0
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = v;
    start_frame();
    @(negedge clk);
    end_frame(0);
    wait_done(dcyc);
    check("sb_empty_b", 32'(sb.size()), 32'd0);

    // --- restarted frame: only the second part counts, clamp exercised
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = v % 4;
    @(negedge clk);
    clr_count = 0;
    start_frame();
    @(negedge clk);
    pixels(3);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    @(negedge clk);
    pixels(2);
    end_frame(2);
    wait_done(dcyc);
    check("unit_clr_pulses", 32'(clr_count), 32'd2);
    check("sb_empty_c", 32'(sb.size()), 32'd0);

    // --- frame_start during scan of bin 10
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = v % 6;
    @(negedge clk);
    start_frame();
    @(negedge clk);
    pixels(5);
    end_frame(5);
    wait_bin(10);
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    check("overrun_pulse", 32'(overrun), 32'd1);
    check("overrun_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("overrun_once", 32'(overrun), 32'd0);
    check("overrun_no_clr", 32'(unit_clr), 32'd0);
    wait_done(dcyc);
    check("sb_empty_d", 32'(sb.size()), 32'd0);

    // --- reset during DIV of bin 5
    for (int v = 0; v < NBIN; v++) cdf_tab[v] = v;
    @(negedge clk);
    start_frame();
    @(negedge clk);
    pixels(3);
    end_frame(3);
    wait_bin(5);                            // SEL of bin 5
    @(negedge clk);                         // LATCH
    @(negedge clk);                         // DIV
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check_idle("mid_rst");
    rst = 1'b0;
    snap = wr_count;
    repeat (100) @(negedge clk);
    check("wr_after_rst", 32'(wr_count - snap), 32'd0);
    check("busy_after_rst", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ch_frame_sequencer.md
Name: ch_frame_sequencer

Overview:
- Frame-level controller for the cumulative-histogram bank. Each bank unit counts the frame pixels whose value is <= its own reference value, giving one CDF value per unit.
- Per frame, this block: clears the bank, gates pixel-valid into the bank and counts frame pixels, then scans every bin.
- For each bin it scales the CDF into an equalization LUT entry, lut[v] = cdf[v]*MAXV/pix_count, using a serial divider, and writes that entry to the downstream LUT RAM.

Parameters:
- PixelSize, 8, pixel/bin index width; MAXV = 2^PixelSize-1.
- histoWidth, $clog2(640*480) (=19), CDF and pixel-counter width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- frame_start  in  1  single-cycle start-of-frame pulse.
- frame_end  in  1  single-cycle end-of-frame pulse.
- pix_valid_in  in  1  pixel strobe from the source.
- pix_valid_out  out  1  pixel strobe forwarded to the bank.
- unit_clr  out  1  bank clear, OR'd externally into the units' reset.
- bin_sel  out  PixelSize  bin being read; selects the external CDF mux.
- cdf_in  in  histoWidth  CDF of the selected bin; valid one cycle after bin_sel changes.
- lut_wr_en  out  1  LUT write strobe.
- lut_addr  out  PixelSize  LUT write address.
- lut_data  out  PixelSize  LUT write data.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last LUT write.
- overrun  out  1  one-cycle pulse when frame_start arrives during a scan.

Behaviour:
- Reset: state=IDLE. All outputs are 0; bin_sel=0; pix_count=0. Reset takes effect in any state, including mid-scan, and no further LUT writes occur after it.
- IDLE:
  - frame_start -> CLEAR.
  - frame_end is ignored.
- CLEAR (1 cycle):
  - unit_clr=1, pix_count<=0.
  - pix_valid_out=0; a pixel arriving in this cycle is dropped.
  - -> ACCUM.
- ACCUM:
  - pix_valid_out = pix_valid_in (combinational).
  - pix_count increments on each valid and saturates at 2^histoWidth-1.
  - frame_start -> CLEAR; the frame restarts and the partial count is discarded.
  - frame_end -> SEL with bin<=0. A pixel valid in the same cycle as frame_end is forwarded and counted.
  - If frame_start and frame_end are both high, frame_start wins.
- SEL (1 cycle): bin_sel=bin -> LATCH.
- LATCH (1 cycle):
  - Capture cdf_in.
  - Load divider: numerator = cdf*MAXV, (histoWidth+PixelSize) bits; divisor = pix_count.
  - -> DIV.
- DIV (D = histoWidth+PixelSize cycles, 27 at default):
  - Restoring divider, one quotient bit per cycle, MSB first.
  - Quotient is clamped to MAXV.
  - If pix_count==0, the result is forced to 0; the divider is still run for D cycles so timing stays fixed.
  - -> WRITE.
- WRITE (1 cycle):
  - lut_wr_en=1, lut_addr=bin, lut_data=quotient.
  - If bin==MAXV -> DONE; else bin<=bin+1 -> SEL.
- DONE (1 cycle): done=1 -> IDLE.
- Timing:
  - Per bin: D+3 cycles, 30 at default.
  - frame_end sampled at edge k: first lut_wr_en high in cycle k+D+3.
  - Final write is in cycle k+256*(D+3); done is high in the following cycle.
- While in SEL/LATCH/DIV/WRITE/DONE:
  - pix_valid_out=0.
  - frame_start raises overrun for 1 cycle and is otherwise ignored.
  - frame_end is ignored.
- bin_sel holds its value from SEL until the next SEL; it is 0 in IDLE.
- busy is a registered decode of the state.

Test Plan:
- Reset mid-DIV of bin 5 -> next cycle all outputs 0, busy=0; no lut_wr_en afterwards.
- 4-pixel frame, bench CDF model: cdf[0]=1, cdf[1..254]=2, cdf[255]=4 -> writes (0,63), (1..254,127), (255,255). First write at k+30; done at k+7681.
- frame_start immediately followed by frame_end with no pixels -> all 256 entries written 0, then done.
- frame_start, 3 valids, frame_start again, 2 valids, frame_end -> unit_clr pulses twice; divisor=2.
- frame_start during the scan of bin 10 -> overrun pulse; scan completes; busy stays 1 until done.
- pix_valid_in during CLEAR -> not forwarded, not counted; pix_valid_in together with frame_end -> counted.
